// File: rtl/lcd12864_bus_if_if.sv
// ---------------------------------------------------------------------------
// lcd12864_bus_if_if
//   Request handshake between the text/command sequencer and the ST7920
//   parallel-bus timing engine (lcd12864_bus_if).
//
//   Signals:
//     req_valid  sequencer has a byte to write
//     req_rs     0 = instruction, 1 = display data
//     req_data   byte to write
//     req_ready  engine accepts a request this cycle (registered)
//     init_done  power-up wait (and built-in init, if enabled) complete
//
//   Modports:
//     master  sequencer side (drives the request)
//     slave   bus engine side (drives ready / init_done)
// ---------------------------------------------------------------------------
interface lcd12864_bus_if_if;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;

    modport master (
        output req_valid, req_rs, req_data,
        input  req_ready, init_done
    );

    modport slave (
        input  req_valid, req_rs, req_data,
        output req_ready, init_done
    );
endinterface

// File: rtl/lcd12864_bus_if.sv
// ---------------------------------------------------------------------------
// lcd12864_bus_if
//   Physical-bus timing engine for an ST7920 128x64 LCD in 8-bit parallel,
//   write-only mode. Takes one {rs, byte} request at a time from the
//   sequencer and plays it onto the LCD pins with setup, enable-pulse,
//   hold and execution-wait timing derived from the system clock.
//
//   Ports:
//     clk      system clock (50 MHz nominal)
//     rst_n    asynchronous active-low reset
//     bus      request handshake (slave modport): req_valid/req_rs/req_data
//              in, req_ready/init_done out
//     lcd_rs   LCD register select
//     lcd_rw   LCD read/write, always 0 (write)
//     lcd_en   LCD enable strobe, straight from a flop
//     lcd_dat  LCD data bus
//
//   Build option:
//     LCD12864_INIT_EN  when defined, the engine writes 30/0C/06/01 (rs = 0)
//                       on its own after the power-up wait and only then
//                       raises init_done and opens the request port.
// ---------------------------------------------------------------------------
module lcd12864_bus_if #(
    parameter int unsigned T_PWRUP_CYC = 2000000,
    parameter int unsigned T_SETUP_CYC = 4,
    parameter int unsigned T_EN_CYC    = 25,
    parameter int unsigned T_HOLD_CYC  = 5,
    parameter int unsigned T_EXEC_CYC  = 4000,
    parameter int unsigned T_CLR_CYC   = 80000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd12864_bus_if_if.slave     bus,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_en,
    output logic [7:0]           lcd_dat
);

    // A zero-length phase would need a state that lasts no cycles; clamp to 1.
    function automatic int unsigned at_least_1(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned P_PWRUP = at_least_1(T_PWRUP_CYC);
    localparam int unsigned P_SETUP = at_least_1(T_SETUP_CYC);
    localparam int unsigned P_EN    = at_least_1(T_EN_CYC);
    localparam int unsigned P_HOLD  = at_least_1(T_HOLD_CYC);
    localparam int unsigned P_EXEC  = at_least_1(T_EXEC_CYC);
    localparam int unsigned P_CLR   = at_least_1(T_CLR_CYC);

    localparam int unsigned P_MAX = max2(max2(max2(P_PWRUP, P_SETUP), max2(P_EN, P_HOLD)),
                                         max2(P_EXEC, P_CLR));
    localparam int unsigned CW    = $clog2(P_MAX) + 1;

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [CW-1:0] LAST_PWRUP = CW'(P_PWRUP - 1);
    localparam logic [CW-1:0] LAST_SETUP = CW'(P_SETUP - 1);
    localparam logic [CW-1:0] LAST_EN    = CW'(P_EN - 1);
    localparam logic [CW-1:0] LAST_HOLD  = CW'(P_HOLD - 1);
    localparam logic [CW-1:0] LAST_EXEC  = CW'(P_EXEC - 1);
    localparam logic [CW-1:0] LAST_CLR   = CW'(P_CLR - 1);

    localparam logic [7:0] CMD_CLEAR = 8'h01;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q;
    logic          done_q, done_d;
    logic          load;        // latch a new {rs, byte} onto the pins
    logic          load_rs;
    logic [7:0]    load_dat;
    logic [CW-1:0] wait_last;

`ifdef LCD12864_INIT_EN
    logic [1:0]    init_idx_q, init_idx_d;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h30;  // basic instruction set, 8-bit bus
            2'd1:    return 8'h0C;  // display on, cursor off
            2'd2:    return 8'h06;  // entry mode: increment, no shift
            default: return 8'h01;  // clear display
        endcase
    endfunction
`endif

    // The clear instruction needs a much longer execution wait. lcd_rs and
    // lcd_dat are frozen from SETUP onward, so they describe the byte whose
    // execution we are waiting out.
    assign wait_last = (!lcd_rs && lcd_dat == CMD_CLEAR) ? LAST_CLR : LAST_EXEC;

    // -----------------------------------------------------------------------
    // Next-state / control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        done_d   = done_q;
        load     = 1'b0;
        load_rs  = 1'b0;
        load_dat = 8'h00;
`ifdef LCD12864_INIT_EN
        init_idx_d = init_idx_q;
`endif

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == LAST_PWRUP) begin
`ifdef LCD12864_INIT_EN
                    state_d    = S_SETUP;
                    load       = 1'b1;
                    load_rs    = 1'b0;
                    load_dat   = init_byte(2'd0);
                    init_idx_d = 2'd0;
`else
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`endif
                end
            end

            S_IDLE: begin
                // ready_q is only ever set in IDLE, so one request per visit.
                if (bus.req_valid && ready_q) begin
                    state_d  = S_SETUP;
                    load     = 1'b1;
                    load_rs  = bus.req_rs;
                    load_dat = bus.req_data;
                end
            end

            S_SETUP: begin
                if (cnt_q == LAST_SETUP) state_d = S_EN_HI;
            end

            S_EN_HI: begin
                if (cnt_q == LAST_EN) state_d = S_HOLD;
            end

            S_HOLD: begin
                if (cnt_q == LAST_HOLD) state_d = S_WAIT;
            end

            S_WAIT: begin
                if (cnt_q == wait_last) begin
`ifdef LCD12864_INIT_EN
                    // done_q low here means we are still in the built-in
                    // init sequence rather than serving the sequencer.
                    if (!done_q && init_idx_q != 2'd3) begin
                        state_d    = S_SETUP;
                        init_idx_d = init_idx_q + 2'd1;
                        load       = 1'b1;
                        load_rs    = 1'b0;
                        load_dat   = init_byte(init_idx_q + 2'd1);
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end

            default: begin
                state_d = S_PWRUP;
            end
        endcase

        // Every phase starts counting from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    // -----------------------------------------------------------------------
    // State and output registers. All pin drivers come from flops so lcd_en
    // cannot glitch; they are computed from the next state so each pin
    // changes on the same edge as the state it belongs to.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            lcd_en  <= 1'b0;
            lcd_rs  <= 1'b0;
            lcd_dat <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == S_IDLE);
            done_q  <= done_d;
            lcd_en  <= (state_d == S_EN_HI);
            if (load) begin
                lcd_rs  <= load_rs;
                lcd_dat <= load_dat;
            end
        end
    end

`ifdef LCD12864_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_idx_q <= 2'd0;
        else        init_idx_q <= init_idx_d;
    end
`endif

    assign lcd_rw        = 1'b0;
    assign bus.req_ready = ready_q;
    assign bus.init_done = done_q;

endmodule
